alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 166 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Purpose:
//   Single-entry issue stage in front of an external combinational ALU.
//   A request is decoded on acceptance into an ALU op code and operand pair.
//   The decoded values are latched and driven to the ALU for one EXEC cycle.
//   The ALU result is then registered and offered downstream until it is taken.
//
// Handshake (valid/ready):
//   A transfer happens on a rising clk edge where valid & ready are both 1.
//   The producer keeps valid and its payload stable until that edge.
//   The consumer may drive ready at any time, and ready may depend on valid.
//   Upstream is io_in_valid/io_in_ready; downstream is io_out_valid/io_out_ready.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   io_in_*           request: valid/ready, aluop, funct, shamt, operands a/b
//   io_alu_op/a/b     latched op code and operands driven to the ALU
//   io_alu_out/zero   combinational ALU result and zero flag
//   io_out_*          registered result: valid/ready, result, zero, illegal
//   io_dbg_state      current FSM state (0 IDLE, 1 EXEC, 2 DONE)
// -----------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [1:0]       io_in_aluop,
  input  logic [5:0]       io_in_funct,
  input  logic [4:0]       io_in_shamt,
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  output logic [2:0]       io_alu_op,
  output logic [WIDTH-1:0] io_alu_a,
  output logic [WIDTH-1:0] io_alu_b,
  input  logic [WIDTH-1:0] io_alu_out,
  input  logic             io_alu_zero,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_result,
  output logic             io_out_zero,
  output logic             io_out_illegal,
  output logic [1:0]       io_dbg_state
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_SRL  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_SLTU = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_illegal;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_out_illegal;

  logic [2:0]       w_op;
  logic             w_illegal;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_accept;

  // Never ready while reset is high, so nothing is accepted on a reset edge.
  always_comb begin
    io_in_ready = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IDLE:  io_in_ready = 1'b1;
        S_DONE:  io_in_ready = io_out_ready;
        default: io_in_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = io_in_valid & io_in_ready;

  // Decode: illegal encodings fall back to AND; their result is overridden at capture.
  always_comb begin
    w_op      = OP_AND;
    w_illegal = 1'b0;
    case (io_in_aluop)
      2'd0: w_op = OP_ADD;
      2'd1: w_op = OP_SUB;
      2'd2: begin
        case (io_in_funct)
          6'h24:        w_op = OP_AND;
          6'h25:        w_op = OP_OR;
          6'h20, 6'h21: w_op = OP_ADD;
          6'h26:        w_op = OP_XOR;
          6'h27:        w_op = OP_NOR;
          6'h02:        w_op = OP_SRL;
          6'h22, 6'h23: w_op = OP_SUB;
          6'h2B:        w_op = OP_SLTU;
          default:      w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // SRL shifts rt by shamt, so the ALU sees (rt, shamt) instead of (rs, rt).
  assign w_a = (w_op == OP_SRL) ? io_in_b : io_in_a;
  assign w_b = (w_op == OP_SRL) ? {{(WIDTH-5){1'b0}}, io_in_shamt} : io_in_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_illegal     <= 1'b0;
      r_result      <= '0;
      r_zero        <= 1'b0;
      r_out_illegal <= 1'b0;
    end else begin
      // Acceptance is only possible in IDLE, or in DONE with io_out_ready high.
      if (w_accept) begin
        r_op      <= w_op;
        r_a       <= w_a;
        r_b       <= w_b;
        r_illegal <= w_illegal;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_result      <= r_illegal ? '0 : io_alu_out;
          r_zero        <= r_illegal ? 1'b1 : io_alu_zero;
          r_out_illegal <= r_illegal;
          r_state       <= S_DONE;
        end
        S_DONE: begin
          if (io_out_ready) r_state <= w_accept ? S_EXEC : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_alu_op      = r_op;
  assign io_alu_a       = r_a;
  assign io_alu_b       = r_b;
  assign io_out_valid   = (r_state == S_DONE);
  assign io_out_result  = r_result;
  assign io_out_zero    = r_zero;
  assign io_out_illegal = r_out_illegal;
  assign io_dbg_state   = r_state;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed bench for alu_issue_stage. A small behavioural ALU drives
// io_alu_out/io_alu_zero from io_alu_op/a/b. Inputs change 1 ns after the
// rising edge, and outputs are checked mid-cycle.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

  logic        clk;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [1:0]  io_in_aluop;
  logic [5:0]  io_in_funct;
  logic [4:0]  io_in_shamt;
  logic [31:0] io_in_a;
  logic [31:0] io_in_b;
  logic [2:0]  io_alu_op;
  logic [31:0] io_alu_a;
  logic [31:0] io_alu_b;
  logic [31:0] io_alu_out;
  logic        io_alu_zero;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_result;
  logic        io_out_zero;
  logic        io_out_illegal;
  logic [1:0]  io_dbg_state;

  int checks;
  int failures;

  alu_issue_stage #(.WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .io_in_valid    (io_in_valid),
    .io_in_ready    (io_in_ready),
    .io_in_aluop    (io_in_aluop),
    .io_in_funct    (io_in_funct),
    .io_in_shamt    (io_in_shamt),
    .io_in_a        (io_in_a),
    .io_in_b        (io_in_b),
    .io_alu_op      (io_alu_op),
    .io_alu_a       (io_alu_a),
    .io_alu_b       (io_alu_b),
    .io_alu_out     (io_alu_out),
    .io_alu_zero    (io_alu_zero),
    .io_out_valid   (io_out_valid),
    .io_out_ready   (io_out_ready),
    .io_out_result  (io_out_result),
    .io_out_zero    (io_out_zero),
    .io_out_illegal (io_out_illegal),
    .io_dbg_state   (io_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural ALU
  always_comb begin
    io_alu_out = 32'd0;
    case (io_alu_op)
      3'd0: io_alu_out = io_alu_a & io_alu_b;
      3'd1: io_alu_out = io_alu_a | io_alu_b;
      3'd2: io_alu_out = io_alu_a + io_alu_b;
      3'd3: io_alu_out = io_alu_a ^ io_alu_b;
      3'd4: io_alu_out = ~(io_alu_a | io_alu_b);
      3'd5: io_alu_out = io_alu_a >> io_alu_b[4:0];
      3'd6: io_alu_out = io_alu_a - io_alu_b;
      default: io_alu_out = {31'd0, (io_alu_a < io_alu_b)};
    endcase
  end
  assign io_alu_zero = (io_alu_out == 32'd0);

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic drive_req(input logic [1:0] aluop, input logic [5:0] funct,
                           input logic [4:0] shamt, input logic [31:0] a,
                           input logic [31:0] b);
    io_in_valid = 1'b1;
    io_in_aluop = aluop;
    io_in_funct = funct;
    io_in_shamt = shamt;
    io_in_a     = a;
    io_in_b     = b;
  endtask

  task automatic idle_req();
    io_in_valid = 1'b0;
    io_in_aluop = 2'd0;
    io_in_funct = 6'd0;
    io_in_shamt = 5'd0;
    io_in_a     = 32'd0;
    io_in_b     = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_req();
    io_out_ready = 1'b1;
    tick(); tick();
    mid();
    checks++;
    if (io_out_valid !== 1'b0 || io_out_result !== 32'd0 || io_out_zero !== 1'b0 || io_out_illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%0b result=%h zero=%0b ill=%0b, required 0/0/0/0",
               io_out_valid, io_out_result, io_out_zero, io_out_illegal);
    end
    checks++;
    if (io_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready: got %0b, required 0", io_in_ready);
    end
    checks++;
    if (io_alu_op !== 3'd0 || io_alu_a !== 32'd0 || io_alu_b !== 32'd0 || io_dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_latch: op=%0d a=%h b=%h st=%0d, required 0/0/0/0",
               io_alu_op, io_alu_a, io_alu_b, io_dbg_state);
    end
    tick();
    reset = 1'b0;
    mid();
    checks++;
    if (io_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_in_ready: got %0b, required 1", io_in_ready);
    end
    tick();
  endtask

  task automatic test_add();
    io_out_ready = 1'b1;
    drive_req(2'd2, 6'h20, 5'd0, 32'd5, 32'd7);
    tick();
    idle_req();
    mid();
    checks++;
    if (io_alu_op !== 3'd2 || io_alu_a !== 32'd5 || io_alu_b !== 32'd7 ||
        io_out_valid !== 1'b0 || io_in_ready !== 1'b0 || io_dbg_state !== 2'd1) begin
      failures++;
      $display("FAIL add_exec: op=%0d a=%h b=%h ov=%0b ir=%0b st=%0d, required 2/5/7/0/0/1",
               io_alu_op, io_alu_a, io_alu_b, io_out_valid, io_in_ready, io_dbg_state);
    end
    tick();
    mid();
    checks++;
    if (io_out_valid !== 1'b1 || io_out_result !== 32'd12 || io_out_zero !== 1'b0 || io_out_illegal !== 1'b0) begin
      failures++;
      $display("FAIL add_done: ov=%0b result=%h zero=%0b ill=%0b, required 1/0000000c/0/0",
               io_out_valid, io_out_result, io_out_zero, io_out_illegal);
    end
    tick();
    mid();
    checks++;
    if (io_out_valid !== 1'b0 || io_dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL add_idle: ov=%0b st=%0d, required 0/0", io_out_valid, io_dbg_state);
    end
  endtask

  task automatic test_sub_zero();
    io_out_ready = 1'b1;
    drive_req(2'd1, 6'h3F, 5'd0, 32'h1234, 32'h1234);
    tick();
    idle_req();
    mid();
    checks++;
    if (io_alu_op !== 3'd6) begin
      failures++;
      $display("FAIL sub_op: got %0d, required 6", io_alu_op);
    end
    tick();
    mid();
    checks++;
    if (io_out_valid !== 1'b1 || io_out_result !== 32'd0 || io_out_zero !== 1'b1 || io_out_illegal !== 1'b0) begin
      failures++;
      $display("FAIL sub_done: ov=%0b result=%h zero=%0b ill=%0b, required 1/0/1/0",
               io_out_valid, io_out_result, io_out_zero, io_out_illegal);
    end
    tick();
  endtask

  task automatic test_srl();
    io_out_ready = 1'b1;
    drive_req(2'd2, 6'h02, 5'd31, 32'hDEADBEEF, 32'h80000000);
    tick();
    idle_req();
    mid();
    checks++;
    if (io_alu_op !== 3'd5 || io_alu_a !== 32'h80000000 || io_alu_b !== 32'd31) begin
      failures++;
      $display("FAIL srl_exec: op=%0d a=%h b=%h, required 5/80000000/0000001f",
               io_alu_op, io_alu_a, io_alu_b);
    end
    tick();
    mid();
    checks++;
    if (io_out_valid !== 1'b1 || io_out_result !== 32'd1 || io_out_zero !== 1'b0) begin
      failures++;
      $display("FAIL srl_done: ov=%0b result=%h zero=%0b, required 1/00000001/0",
               io_out_valid, io_out_result, io_out_zero);
    end
    tick();
  endtask

  task automatic test_sltu_nor();
    io_out_ready = 1'b1;
    // SLTU 1 < 0xFFFFFFFF unsigned -> 1
    drive_req(2'd2, 6'h2B, 5'd0, 32'd1, 32'hFFFFFFFF);
    tick();
    idle_req();
    tick();
    mid();
    checks++;
    if (io_alu_op !== 3'd7 || io_out_result !== 32'd1) begin
      failures++;
      $display("FAIL sltu: op=%0d result=%h, required 7/00000001", io_alu_op, io_out_result);
    end
    tick();
    // NOR 0x0F0F0000 | 0x0000F0F0 -> ~0x0F0FF0F0 = 0xF0F00F0F
    drive_req(2'd2, 6'h27, 5'd0, 32'h0F0F0000, 32'h0000F0F0);
    tick();
    idle_req();
    tick();
    mid();
    checks++;
    if (io_alu_op !== 3'd4 || io_out_result !== 32'hF0F00F0F) begin
      failures++;
      $display("FAIL nor: op=%0d result=%h, required 4/f0f00f0f", io_alu_op, io_out_result);
    end
    tick();
  endtask

  task automatic test_illegal();
    io_out_ready = 1'b1;
    drive_req(2'd2, 6'h3F, 5'd0, 32'h3, 32'h3);
    tick();
    idle_req();
    mid();
    checks++;
    if (io_alu_op !== 3'd0 || io_dbg_state !== 2'd1) begin
      failures++;
      $display("FAIL illegal_exec: op=%0d st=%0d, required 0/1", io_alu_op, io_dbg_state);
    end
    tick();
    mid();
    checks++;
    if (io_out_valid !== 1'b1 || io_out_illegal !== 1'b1 || io_out_result !== 32'd0 || io_out_zero !== 1'b1) begin
      failures++;
      $display("FAIL illegal_funct: ov=%0b ill=%0b result=%h zero=%0b, required 1/1/0/1",
               io_out_valid, io_out_illegal, io_out_result, io_out_zero);
    end
    tick();
    mid();
    checks++;
    if (io_dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL illegal_handshake: st=%0d, required 0", io_dbg_state);
    end
    // aluop 3 is reserved
    drive_req(2'd3, 6'h20, 5'd0, 32'h5, 32'h7);
    tick();
    idle_req();
    tick();
    mid();
    checks++;
    if (io_out_illegal !== 1'b1 || io_out_result !== 32'd0 || io_out_zero !== 1'b1) begin
      failures++;
      $display("FAIL illegal_aluop3: ill=%0b result=%h zero=%0b, required 1/0/1",
               io_out_illegal, io_out_result, io_out_zero);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    io_out_ready = 1'b0;
    drive_req(2'd2, 6'h25, 5'd0, 32'hF0, 32'h0F);
    tick();
    idle_req();
    tick();
    for (int i = 0; i < 5; i++) begin
      mid();
      checks++;
      if (io_out_valid !== 1'b1 || io_out_result !== 32'hFF || io_out_zero !== 1'b0 ||
          io_out_illegal !== 1'b0 || io_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: ov=%0b result=%h zero=%0b ill=%0b ir=%0b, required 1/000000ff/0/0/0",
                 i, io_out_valid, io_out_result, io_out_zero, io_out_illegal, io_in_ready);
      end
      tick();
    end
    io_out_ready = 1'b1;
    drive_req(2'd2, 6'h26, 5'd0, 32'hFF, 32'h0F);
    mid();
    checks++;
    if (io_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_in_ready: got %0b, required 1", io_in_ready);
    end
    tick();
    idle_req();
    mid();
    checks++;
    if (io_dbg_state !== 2'd1 || io_alu_op !== 3'd3 || io_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_exec: st=%0d op=%0d ov=%0b, required 1/3/0", io_dbg_state, io_alu_op, io_out_valid);
    end
    tick();
    mid();
    checks++;
    if (io_out_valid !== 1'b1 || io_out_result !== 32'hF0) begin
      failures++;
      $display("FAIL b2b_done: ov=%0b result=%h, required 1/000000f0", io_out_valid, io_out_result);
    end
    tick();
  endtask

  task automatic test_reset_in_exec();
    io_out_ready = 1'b1;
    drive_req(2'd0, 6'h00, 5'd0, 32'd100, 32'd23);
    tick();
    idle_req();
    mid();
    checks++;
    if (io_dbg_state !== 2'd1 || io_alu_op !== 3'd2) begin
      failures++;
      $display("FAIL rexec_pre: st=%0d op=%0d, required 1/2", io_dbg_state, io_alu_op);
    end
    reset = 1'b1;
    tick();
    mid();
    checks++;
    if (io_dbg_state !== 2'd0 || io_out_valid !== 1'b0 || io_out_result !== 32'd0 ||
        io_out_zero !== 1'b0 || io_out_illegal !== 1'b0 || io_alu_op !== 3'd0 ||
        io_alu_a !== 32'd0 || io_alu_b !== 32'd0 || io_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rexec_post: st=%0d ov=%0b res=%h z=%0b ill=%0b op=%0d a=%h b=%h ir=%0b, required all 0",
               io_dbg_state, io_out_valid, io_out_result, io_out_zero, io_out_illegal,
               io_alu_op, io_alu_a, io_alu_b, io_in_ready);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      mid();
      checks++;
      if (io_out_valid !== 1'b0 || io_out_result !== 32'd0) begin
        failures++;
        $display("FAIL rexec_stale%0d: ov=%0b result=%h, required 0/0", i, io_out_valid, io_out_result);
      end
    end
  endtask

  // scoreboard / final report
  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    io_out_ready = 1'b0;
    idle_req();
    test_reset();
    test_add();
    test_sub_zero();
    test_srl();
    test_sltu_nor();
    test_illegal();
    test_back_to_back();
    test_reset_in_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
